// File: rtl/ram_io_responder.sv
// Responder end of the byte-serial RAM bus: main RAM array plus a DATA/STATUS
// IO pair bridging a TX FIFO (CPU->host) and RX FIFO (host->CPU) to a stream port.

module ram_io_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    buf_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = buf_q[rd_ptr_q];

  // A push is refused when full even if a pop happens in the same cycle.
  assign push_ok = rst & push_i & ~full_o;
  assign pop_ok  = rst & pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) buf_q[wr_ptr_q] <= din_i;
  end
endmodule

module ram_io_responder #(
  parameter int          ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready,
  output logic        io_busy
);
  localparam logic [31:0] STAT_ADDR = IO_BASE + 32'd4;

  logic [7:0]            ram [1 << ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  is_data, is_stat, is_ram, wr_acc, rd_acc;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]            rx_head;
  logic                  ovf_q, ovf_d;
  logic [7:0]            dout_q, dout_d;

  assign ram_idx = mem_a[ADDR_WIDTH-1:0];
  assign is_data = (mem_a == IO_BASE);
  assign is_stat = (mem_a == STAT_ADDR);
  assign is_ram  = ~is_data & ~is_stat;
  assign wr_acc  = rst & mem_en & mem_wr;
  assign rd_acc  = rst & mem_en & ~mem_wr;

  ram_io_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst),
    .push_i(wr_acc & is_data), .din_i(mem_din),
    .pop_i(io_tx_ready),
    .head_o(io_tx_data), .full_o(tx_full), .empty_o(tx_empty)
  );

  ram_io_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst),
    .push_i(io_rx_valid & io_rx_ready), .din_i(io_rx_data),
    .pop_i(rd_acc & is_data),
    .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  assign io_tx_valid = ~tx_empty;
  assign io_busy     = tx_full;
  assign io_rx_ready = rst & ~rx_full;
  assign mem_dout    = dout_q;

  // Overflow set takes priority over the read-to-clear of STATUS.
  always_comb begin
    ovf_d = ovf_q;
    if (rd_acc & is_stat)           ovf_d = 1'b0;
    if (wr_acc & is_data & tx_full) ovf_d = 1'b1;
  end

  // IO read data; RAM reads are handled directly in the output register.
  always_comb begin
    dout_d = 8'h00;
    if (is_data)      dout_d = rx_empty ? 8'h00 : rx_head;
    else if (is_stat) dout_d = {5'b0, ovf_q, ~rx_empty, tx_full};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q  <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      ovf_q <= ovf_d;
      if (rd_acc) dout_q <= is_ram ? ram[ram_idx] : dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc & is_ram) ram[ram_idx] <= mem_din;
  end
endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: expected read bytes and TX stream
// bytes are queued at stimulus time and compared as the DUT produces them.

module tb_ram_io_responder;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [31:0] STAT    = 32'h0003_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_din, mem_dout;
  logic [7:0]  io_tx_data, io_rx_data;
  logic        io_tx_valid, io_tx_ready, io_rx_valid, io_rx_ready, io_busy;

  int errs   = 0;
  int checks = 0;
  logic [7:0] rdq[$];
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  ram_io_responder #(.ADDR_WIDTH(17), .IO_BASE(IO_BASE), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .io_tx_data(io_tx_data), .io_tx_valid(io_tx_valid), .io_tx_ready(io_tx_ready),
    .io_rx_data(io_rx_data), .io_rx_valid(io_rx_valid), .io_rx_ready(io_rx_ready),
    .io_busy(io_busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_en = 1'b1; mem_wr = 1'b1; mem_a = a; mem_din = d;
    cyc();
    mem_en = 1'b0; mem_wr = 1'b0;
  endtask

  // Expected byte is queued when the read is issued and checked after its edge.
  task automatic rd(input string tag, input logic [31:0] a, input logic [7:0] exp);
    mem_en = 1'b1; mem_wr = 1'b0; mem_a = a;
    rdq.push_back(exp);
    cyc();
    mem_en = 1'b0;
    chk(tag, mem_dout, rdq.pop_front());
  endtask

  task automatic host_push(input logic [7:0] d);
    io_rx_valid = 1'b1; io_rx_data = d;
    cyc();
    io_rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; mem_a = '0; mem_din = '0;
    io_tx_ready = 1'b0; io_rx_valid = 1'b0; io_rx_data = '0;
    cyc(); cyc();
    chk("rst_dout", mem_dout, 8'h00);
    chk("rst_txv", io_tx_valid, 1'b0);
    chk("rst_busy", io_busy, 1'b0);
    chk("rst_rxrdy", io_rx_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("rxrdy_after_rst", io_rx_ready, 1'b1);

    // RAM write/read and address truncation alias
    wr(32'h0001_0, 8'hA5);
    rd("ram_rd", 32'h0000_0010, 8'hA5);
    rd("ram_alias", 32'h0002_0010, 8'hA5);

    // mem_en=0 must suppress writes
    wr(32'h0000_0100, 8'h11);
    mem_en = 1'b0; mem_wr = 1'b1; mem_a = 32'h0000_0100; mem_din = 8'h3C;
    repeat (5) cyc();
    mem_wr = 1'b0;
    rd("en_gate", 32'h0000_0100, 8'h11);

    // TX fill and overflow
    for (int i = 1; i <= 10; i++) begin
      wr(IO_BASE, 8'(i));
      if (i <= 8) txq.push_back(8'(i));
      if (i == 7) chk("busy_at7", io_busy, 1'b0);
      if (i == 8) chk("busy_at8", io_busy, 1'b1);
    end
    rd("stat_ovf", STAT, 8'h05);
    rd("stat_ovf_clr", STAT, 8'h01);
    io_tx_ready = 1'b1;
    for (int i = 0; i < 20 && txq.size() > 0; i++) begin
      if (io_tx_valid) chk("tx_byte", io_tx_data, txq.pop_front());
      cyc();
    end
    chk("tx_drained", txq.size(), 0);
    chk("tx_empty", io_tx_valid, 1'b0);
    chk("busy_clr", io_busy, 1'b0);
    io_tx_ready = 1'b0;

    // RX path
    host_push(8'h7E);
    host_push(8'h7F);
    rd("stat_rx", STAT, 8'h02);
    rd("rx0", IO_BASE, 8'h7E);
    rd("rx1", IO_BASE, 8'h7F);
    rd("rx_empty", IO_BASE, 8'h00);
    rd("stat_rx_empty", STAT, 8'h00);

    // RX full backpressure
    for (int i = 0; i < 8; i++) host_push(8'h80 + 8'(i));
    chk("rx_full_rdy", io_rx_ready, 1'b0);
    io_rx_valid = 1'b1; io_rx_data = 8'h99;
    cyc();
    chk("rx_full_hold", io_rx_ready, 1'b0);
    rd("rx_full_pop", IO_BASE, 8'h80);
    chk("rx_freed_rdy", io_rx_ready, 1'b1);
    cyc();
    io_rx_valid = 1'b0;
    chk("rx_refull_rdy", io_rx_ready, 1'b0);
    for (int i = 1; i < 8; i++) rd("rx_drain", IO_BASE, 8'h80 + 8'(i));
    rd("rx_late", IO_BASE, 8'h99);
    rd("rx_after", IO_BASE, 8'h00);

    // RX push into empty FIFO with same-cycle DATA read
    io_rx_valid = 1'b1; io_rx_data = 8'h42;
    rd("rx_push_rd_empty", IO_BASE, 8'h00);
    io_rx_valid = 1'b0;
    rd("rx_push_kept", IO_BASE, 8'h42);

    // Reset mid-operation
    wr(32'h0000_0200, 8'h5A);
    for (int i = 0; i < 3; i++) wr(IO_BASE, 8'hC0 + 8'(i));
    host_push(8'h55);
    rd("pre_rst", 32'h0000_0200, 8'h5A);
    chk("pre_rst_txv", io_tx_valid, 1'b1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_txv", io_tx_valid, 1'b0);
    chk("mid_rst_dout", mem_dout, 8'h00);
    rd("mid_rst_stat", STAT, 8'h00);
    rd("mid_rst_ram", 32'h0000_0200, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
